instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle sequencer that drives the CPU datapath: it owns the program counter, steps each instruction through fetch, execute and memory phases, and gates register-file and data-memory strobes. It sits between instruction memory and the combinational control decoder. It consumes the decoder's Branch, Halt, MemtoReg, MemWrite and RegWrite outputs plus the ALU branch condition. It produces the PC, the instruction-register load strobe, qualified write enables and a Start/Done handshake to the testbench.

## Interface
- PC_W, 10, program-counter width; instruction memory depth is 2^PC_W.
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins execution at StartAddr.
- StartAddr  input  PC_W  first instruction address, sampled on Start.
- Branch, Halt, MemtoReg, MemWrite, RegWrite  input  1 each  decoder outputs for the latched instruction.
- BrTaken  input  1  ALU branch condition (operands not equal).
- BrTarget  input  PC_W  absolute branch target from the target lookup table.
- MemAck  input  1  data memory finished the access; may arrive any number of cycles after MemReq.
- ProgCtr  output  PC_W  current instruction address.
- IrLoad  output  1  latch the instruction-memory output into the instruction register.
- RegWrEn  output  1  qualified register-file write enable.
- MemReq  output  1  data-memory request; held until MemAck.
- MemWrEn  output  1  store qualifier, valid while MemReq is high.
- Done  output  1  program halted; level.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALTED. Encoding is free.
- IDLE: all strobes 0. On Start, ProgCtr <= StartAddr and the next state is FETCH.
- FETCH: IrLoad=1 for exactly one cycle. The next state is EXEC.
- EXEC: decoder inputs are valid for this whole cycle. Exits are checked in this priority order:
  - Halt=1 -> HALTED. ProgCtr is unchanged. No strobes.
  - MemtoReg or MemWrite -> MEM. MemReq=1 is asserted from the first MEM cycle.
  - Otherwise: RegWrEn=RegWrite. ProgCtr <= (Branch && BrTaken) ? BrTarget : ProgCtr+1. The next state is FETCH.
- MEM:
  - MemReq=1 and MemWrEn=MemWrite are held until MemAck=1.
  - In the MemAck cycle: RegWrEn=MemtoReg, ProgCtr <= ProgCtr+1, the next state is FETCH, and MemReq falls in the following cycle.
- HALTED:
  - Done=1 and all other strobes are 0.
  - A Start pulse clears Done, loads StartAddr and goes to FETCH.
- PC arithmetic is modulo 2^PC_W. ProgCtr+1 at all-ones wraps to 0 with no flag.
- Branch to the current address is legal and loops.

## Timing
- Reset values: ProgCtr=0, IrLoad=0, RegWrEn=0, MemReq=0, MemWrEn=0, Done=0, state IDLE.
- Reset asserted in any state (including MEM with an outstanding request) aborts immediately. MemReq drops asynchronously and no write completes.
- Start is ignored in FETCH, EXEC and MEM.
- MemAck outside MEM is ignored.
- MemAck high in the first MEM cycle gives the minimum memory latency.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Memory instruction: 3+W cycles, where W is the number of MEM cycles with MemAck=0.
  - Halt: Done rises on the clock edge ending the EXEC cycle.
- All outputs are registered-state decodes. RegWrEn and MemWrEn are combinational from state and decoder inputs and carry no extra pipeline stage.
- Halt has priority over a simultaneous Branch, MemtoReg or MemWrite.

## Configuration
- INSTR_SEQUENCER_PERF_EN defined:
  - Adds output CycleCnt [31:0] and output InstrCnt [31:0].
  - Both clear on reset and on Start.
  - CycleCnt increments every cycle outside IDLE and HALTED.
  - InstrCnt increments on every exit from EXEC or MEM to FETCH, and on the EXEC-to-HALTED exit.
  - Both saturate at 0xFFFFFFFF and hold their value in HALTED.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- Reset, then Start with StartAddr=0x010, then 3 non-memory instructions, then Halt -> ProgCtr sequence 0x010, 0x011, 0x012, 0x013. Done rises 8 cycles after Start. Perf build: CycleCnt=8, InstrCnt=4.
- Branch=1 in EXEC:
  - BrTaken=1, BrTarget=0x3F0 -> the next FETCH has ProgCtr=0x3F0.
  - BrTaken=0 -> ProgCtr+1.
  - RegWrEn stays 0 in both cases (RegWrite=0).
- Load with MemAck delayed 4 cycles -> MemReq is high for 5 cycles and MemWrEn=0 throughout. RegWrEn pulses once, in the MemAck cycle. PC advances by 1.
- Store with MemAck in the first MEM cycle -> MemReq and MemWrEn are high for exactly 1 cycle, RegWrEn stays 0, and the instruction takes 3 cycles.
- ProgCtr=0x3FF executing a non-branch instruction -> the next ProgCtr is 0x000.
- Reset_n dropped mid-MEM -> all outputs are 0 in the same cycle.
- Start pulsed during EXEC -> ignored.
- Start pulsed in HALTED -> Done clears and execution restarts at StartAddr.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and walks each instruction through FETCH/EXEC/MEM.
// Optional perf counters (CycleCnt, InstrCnt) are built when INSTR_SEQUENCER_PERF_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | out of reset, waiting for Start
// FETCH   | IrLoad pulse, instruction register captures imem output
// EXEC    | decoder outputs valid; branch/halt/memory dispatch
// MEM     | MemReq held until MemAck, then PC+1
// HALTED  | Done level, waiting for Start to restart
module instr_sequencer #(
  parameter int PC_W = 10
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Branch,
  input  logic            Halt,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            BrTaken,
  input  logic [PC_W-1:0] BrTarget,
  input  logic            MemAck,
  output logic [PC_W-1:0] ProgCtr,
  output logic            IrLoad,
  output logic            RegWrEn,
  output logic            MemReq,
  output logic            MemWrEn,
  output logic            Done
`ifdef INSTR_SEQUENCER_PERF_EN
  ,
  output logic [31:0]     CycleCnt,
  output logic [31:0]     InstrCnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_nxt = S_FETCH;
          pc_nxt    = StartAddr;
        end
      end
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        // Halt wins over any branch or memory request decoded alongside it
        if (Halt) begin
          state_nxt = S_HALTED;
        end else if (MemtoReg || MemWrite) begin
          state_nxt = S_MEM;
        end else begin
          RegWrEn   = RegWrite;
          pc_nxt    = (Branch && BrTaken) ? BrTarget : pc_q + PC_ONE;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        MemWrEn = MemWrite;
        if (MemAck) begin
          RegWrEn   = MemtoReg;
          pc_nxt    = pc_q + PC_ONE;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ProgCtr = pc_q;
  assign IrLoad  = (state == S_FETCH);
  assign MemReq  = (state == S_MEM);
  assign Done    = (state == S_HALTED);

`ifdef INSTR_SEQUENCER_PERF_EN
  logic start_acc;
  logic retire;
  logic running;

  assign start_acc = Start && (state == S_IDLE || state == S_HALTED);
  assign running   = (state == S_FETCH || state == S_EXEC || state == S_MEM);
  assign retire    = (state == S_EXEC && (Halt || !(MemtoReg || MemWrite))) ||
                     (state == S_MEM && MemAck);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else if (start_acc) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if (running && CycleCnt != 32'hFFFF_FFFF)
        CycleCnt <= CycleCnt + 32'd1;
      if (retire && InstrCnt != 32'hFFFF_FFFF)
        InstrCnt <= InstrCnt + 32'd1;
    end
  end
`endif

endmodule
